// File: rtl/lab3_pkg.sv
// Shared lab3 definitions: FIFO word geometry, seven-segment codes and the
// read-side FSM state type.
package lab3_pkg;

    localparam int DATA_W  = 24;
    localparam int NIBBLES = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..9, A, b, C, d, E, F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE,
        POP,
        WAIT,
        CAPTURE
    } rd_state_t;

    function automatic logic [6:0] segOf(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_seg7
    import lab3_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = segOf(nibble_i);
    end

endmodule

// File: rtl/fifo_hex_reader.sv
// Read-side consumer for the lab3 24-bit FIFO: pops one entry per debounced key
// press or auto-drain tick and shows it on HEX5..HEX0.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module fifo_hex_reader
    import lab3_pkg::*;
#(
    parameter int DATA_W          = 24,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int RD_LATENCY      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_rd_n,
    input  logic              auto_en,
    input  logic              fifo_notempty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              rd_underflow,
    output logic              busy,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

`ifdef HEX_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic              keyMeta_q;
    logic              keySync_q;
    logic              keyDeb_q;
    logic [DEB_W-1:0]  debCnt_q;
    logic              keyReq_q;
    logic [AUTO_W-1:0] autoCnt_q;
    logic              autoReq;
    logic              req;
    rd_state_t         state_q;
    logic              fifoRd_q;
    logic              underflow_q;
    logic              busy_q;
    logic [DATA_W-1:0] disp_q;
    logic [DATA_W-1:0] disp_d;
    logic [6:0]        segRaw [NIBBLES];
    logic [6:0]        hex_d  [NIBBLES];
    logic [6:0]        hex_q  [NIBBLES];
    logic              upperZero;

    // Key levels are kept as "pressed = 1" from the synchroniser onward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyMeta_q <= 1'b0;
            keySync_q <= 1'b0;
        end else begin
            keyMeta_q <= ~key_rd_n;
            keySync_q <= keyMeta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyDeb_q <= 1'b0;
            debCnt_q <= '0;
            keyReq_q <= 1'b0;
        end else begin
            keyReq_q <= 1'b0;
            if (keySync_q != keyDeb_q) begin
                if (debCnt_q == DEB_LAST) begin
                    keyDeb_q <= keySync_q;
                    debCnt_q <= '0;
                    keyReq_q <= keySync_q;
                end else begin
                    debCnt_q <= debCnt_q + DEB_W'(1);
                end
            end else begin
                debCnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            autoCnt_q <= '0;
        end else if (!auto_en) begin
            autoCnt_q <= '0;
        end else if (autoCnt_q == AUTO_LAST) begin
            autoCnt_q <= '0;
        end else begin
            autoCnt_q <= autoCnt_q + AUTO_W'(1);
        end
    end

    assign autoReq = auto_en && (autoCnt_q == AUTO_LAST);
    assign req     = keyReq_q | autoReq;

    // Requests seen outside IDLE are simply dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fifoRd_q    <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fifoRd_q    <= 1'b0;
            underflow_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && fifo_notempty) begin
                        state_q  <= POP;
                        fifoRd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (keyReq_q && !fifo_notempty) begin
                        underflow_q <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= (RD_LATENCY == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        disp_d = disp_q;
        if (state_q == CAPTURE) begin
            disp_d = fifo_rdata;
        end
    end

    for (genvar g = 0; g < NIBBLES; g++) begin : gSeg
        hex_to_seg7 u_seg (
            .nibble_i (disp_d[4*g +: 4]),
            .seg_o    (segRaw[g])
        );
    end

    // Digits are decoded from the next display value so HEX tracks disp_q
    always_comb begin
        upperZero = 1'b1;
        for (int i = 0; i < NIBBLES; i++) begin
            hex_d[i] = segRaw[i];
        end
        for (int i = NIBBLES - 1; i >= 1; i--) begin
            upperZero = upperZero && (disp_d[4*i +: 4] == 4'h0);
            if (BLANK_EN && upperZero) begin
                hex_d[i] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            for (int i = 0; i < NIBBLES; i++) begin
                hex_q[i] <= (BLANK_EN && (i > 0)) ? SEG_BLANK : SEG_TABLE[0];
            end
        end else begin
            disp_q <= disp_d;
            for (int i = 0; i < NIBBLES; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign fifo_rd      = fifoRd_q;
    assign rd_underflow = underflow_q;
    assign busy         = busy_q;
    assign HEX0         = hex_q[0];
    assign HEX1         = hex_q[1];
    assign HEX2         = hex_q[2];
    assign HEX3         = hex_q[3];
    assign HEX4         = hex_q[4];
    assign HEX5         = hex_q[5];

endmodule

// File: tb/tb_fifo_hex_reader.sv
// Directed bench for fifo_hex_reader with a small behavioural FIFO on the read
// side; expected displays come from hand-written segment codes.
module tb_fifo_hex_reader;

    logic        clk;
    logic        rst_n;
    logic        key_rd_n;
    logic        auto_en;
    logic        fifo_notempty;
    logic [23:0] fifo_rdata;
    logic        fifo_rd;
    logic        rd_underflow;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;
    int cycleCount = 0;
    int rdPulses = 0;
    int ufPulses = 0;
    int rdAt [8];

    logic [23:0] fifoMem [8];
    int wrCount = 0;
    int rdPtr   = 0;

    logic [6:0] segTable [16];

    fifo_hex_reader #(
        .DATA_W          (24),
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (16),
        .RD_LATENCY      (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_rd_n      (key_rd_n),
        .auto_en       (auto_en),
        .fifo_notempty (fifo_notempty),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd       (fifo_rd),
        .rd_underflow  (rd_underflow),
        .busy          (busy),
        .HEX0          (HEX0),
        .HEX1          (HEX1),
        .HEX2          (HEX2),
        .HEX3          (HEX3),
        .HEX4          (HEX4),
        .HEX5          (HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_notempty = (rdPtr < wrCount);

    // FIFO model: a pop seen during a cycle presents data from the next edge on
    initial begin
        logic pend;
        fifo_rdata = 24'h0;
        forever begin
            @(negedge clk);
            pend = fifo_rd;
            @(posedge clk);
            #1;
            if (pend && rdPtr < wrCount) begin
                fifo_rdata = fifoMem[rdPtr];
                rdPtr = rdPtr + 1;
            end
        end
    end

    function automatic logic [41:0] expectHex(input logic [23:0] v);
        logic [41:0] r;
        logic        zeroAbove;
        zeroAbove = 1'b1;
        r = '0;
        for (int i = 5; i >= 0; i--) begin
            r[7*i +: 7] = segTable[v[4*i +: 4]];
`ifdef HEX_LEADING_ZERO_BLANK_EN
            zeroAbove = zeroAbove && (v[4*i +: 4] == 4'h0);
            if (i > 0 && zeroAbove) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            cycleCount = cycleCount + 1;
            if (fifo_rd === 1'b1) begin
                if (rdPulses < 8) rdAt[rdPulses] = cycleCount;
                rdPulses = rdPulses + 1;
            end
            if (rd_underflow === 1'b1) ufPulses = ufPulses + 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total = total + 1;
        assert (observed === expected) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadFifo(input int n, input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] c);
        fifoMem[0] = a;
        fifoMem[1] = b;
        fifoMem[2] = c;
        rdPtr   = 0;
        wrCount = n;
    endtask

    function automatic logic [41:0] hexBus();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    initial begin
        int start;
        logic seen;
        segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n    = 1'b0;
        key_rd_n = 1'b1;
        auto_en  = 1'b0;
        loadFifo(0, 24'h0, 24'h0, 24'h0);

        $display("[TB] reset");
        applyStimulus(3);
        checkOutput("resetHex", 64'(hexBus()), 64'(expectHex(24'h000000)));
        checkOutput("resetFifoRd", 64'(fifo_rd), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetUnderflow", 64'(rd_underflow), 64'd0);
        rst_n = 1'b1;
        applyStimulus(2);

        $display("[TB] key pop 12AB3F");
        loadFifo(1, 24'h12AB3F, 24'h0, 24'h0);
        rdPulses = 0;
        start = cycleCount;
        key_rd_n = 1'b0;
        applyStimulus(8);
        checkOutput("keyHexBefore", 64'(hexBus()), 64'(expectHex(24'h000000)));
        applyStimulus(1);
        checkOutput("keyHexAfter", 64'(hexBus()), 64'(expectHex(24'h12AB3F)));
        applyStimulus(1);
        checkOutput("keyPopCount", 64'(rdPulses), 64'd1);
        checkOutput("keyPopCycle", 64'(rdAt[0] - start), 64'd7);
        checkOutput("keyBusyIdle", 64'(busy), 64'd0);
        key_rd_n = 1'b1;
        applyStimulus(10);

        $display("[TB] underflow");
        rdPulses = 0;
        ufPulses = 0;
        key_rd_n = 1'b0;
        applyStimulus(6);
        checkOutput("ufEarly", 64'(rd_underflow), 64'd0);
        applyStimulus(1);
        checkOutput("ufPulse", 64'(rd_underflow), 64'd1);
        applyStimulus(3);
        checkOutput("ufCount", 64'(ufPulses), 64'd1);
        checkOutput("ufNoPop", 64'(rdPulses), 64'd0);
        checkOutput("ufHexHeld", 64'(hexBus()), 64'(expectHex(24'h12AB3F)));
        key_rd_n = 1'b1;
        applyStimulus(10);

        $display("[TB] bounce then hold");
        loadFifo(2, 24'h654321, 24'hFEDCBA, 24'h0);
        rdPulses = 0;
        ufPulses = 0;
        for (int i = 0; i < 10; i++) begin
            key_rd_n = (i % 2 == 1);
            applyStimulus(2);
        end
        applyStimulus(8);
        checkOutput("bounceNoPop", 64'(rdPulses), 64'd0);
        key_rd_n = 1'b0;
        applyStimulus(100);
        checkOutput("holdOnePop", 64'(rdPulses), 64'd1);
        checkOutput("holdHex", 64'(hexBus()), 64'(expectHex(24'h654321)));
        key_rd_n = 1'b1;
        applyStimulus(10);

        $display("[TB] auto drain");
        loadFifo(3, 24'h000001, 24'h000002, 24'h000003);
        rdPulses = 0;
        ufPulses = 0;
        start = cycleCount;
        auto_en = 1'b1;
        applyStimulus(70);
        auto_en = 1'b0;
        checkOutput("autoPopCount", 64'(rdPulses), 64'd3);
        checkOutput("autoPop0", 64'(rdAt[0] - start), 64'd16);
        checkOutput("autoPop1", 64'(rdAt[1] - start), 64'd32);
        checkOutput("autoPop2", 64'(rdAt[2] - start), 64'd48);
        checkOutput("autoNoUnderflow", 64'(ufPulses), 64'd0);
        checkOutput("autoHex", 64'(hexBus()), 64'(expectHex(24'h000003)));
        applyStimulus(2);

        $display("[TB] reset during pop");
        loadFifo(1, 24'h0000A5, 24'h0, 24'h0);
        key_rd_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            applyStimulus(1);
            seen = (fifo_rd === 1'b1);
        end
        checkOutput("midPopSeen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        key_rd_n = 1'b1;
        #1;
        checkOutput("midResetFifoRd", 64'(fifo_rd), 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetHex", 64'(hexBus()), 64'(expectHex(24'h000000)));
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(10);

        $display("[TB] display 0000A5");
        loadFifo(1, 24'h0000A5, 24'h0, 24'h0);
        key_rd_n = 1'b0;
        applyStimulus(12);
        key_rd_n = 1'b1;
        applyStimulus(10);
        checkOutput("a5Hex", 64'(hexBus()), 64'(expectHex(24'h0000A5)));
        checkOutput("a5Hex1", 64'(HEX1), 64'h08);
        checkOutput("a5Hex0", 64'(HEX0), 64'h12);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        checkOutput("a5Hex5", 64'(HEX5), 64'h7F);
`else
        checkOutput("a5Hex5", 64'(HEX5), 64'h40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_hex_reader.md
Name: fifo_hex_reader

Overview:
- Read-side consumer for the lab3 24-bit FIFO. A read request pops one entry and shows it as six hex digits on HEX5..HEX0.
- A read request is either a debounced key press or an auto-drain tick.
- Sits between the FIFO controller/memory and the seven-segment pins. It is the reader counterpart to the key-driven write path.

Parameters:
- DATA_W, 24, FIFO word width; must equal 4*6.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a key level (10 ms at 50 MHz). Bench uses 4.
- AUTO_PERIOD, 50000000, cycles between auto-drain pops (1 s at 50 MHz). Bench uses 16.
- RD_LATENCY, 1, cycles from fifo_rd to valid fifo_rdata; legal values 1..2.

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- key_rd_n  in  1  raw read button, active-low, asynchronous to clk
- auto_en  in  1  level; 1 enables periodic auto-drain
- fifo_notempty  in  1  FIFO holds at least one entry
- fifo_rdata  in  DATA_W  FIFO read data, valid RD_LATENCY cycles after fifo_rd
- fifo_rd  out  1  single-cycle pop strobe
- rd_underflow  out  1  single-cycle pulse: key request while FIFO empty
- busy  out  1  pop in flight (state != IDLE)
- HEX0..HEX5  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 = bits[3:0], HEX5 = bits[23:20]

Behaviour:
- Reset (async assert, sync deassert via rst_n):
  - fifo_rd=0, rd_underflow=0, busy=0.
  - Display register = 24'h000000, so every HEX shows "0" = 7'b1000000.
  - Debouncer state = released; auto counter = 0; FSM = IDLE.
  - Reset mid-pop abandons the pop; the display returns to zeros.
- Key path:
  - Two-flop synchroniser, then a debounce counter.
  - The debounced level flips only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A single-cycle key_req is generated on the debounced released->pressed transition.
  - Holding the key produces no repeats; a release must also debounce before the next press counts.
- Auto path:
  - While auto_en=1, the counter runs 0..AUTO_PERIOD-1. auto_req pulses on terminal count, then the counter wraps to 0.
  - auto_en=0 clears the counter synchronously.
- Arbitration: req = key_req | auto_req. A coincident pair is one request.
- FSM states IDLE, POP, WAIT, CAPTURE:
  - IDLE & req & fifo_notempty -> POP.
  - IDLE & key_req & !fifo_notempty -> rd_underflow=1 for that cycle; stay IDLE; display unchanged.
  - IDLE & auto_req & !fifo_notempty -> stay IDLE silently (no underflow).
  - POP: fifo_rd=1 for exactly one cycle. Then go to CAPTURE if RD_LATENCY=1, else to WAIT.
  - WAIT: one cycle, then CAPTURE.
  - CAPTURE: display register <= fifo_rdata; return to IDLE.
  - The display updates on the clock edge ending CAPTURE.
  - Requests arriving while busy=1 are dropped, not queued.
- fifo_rd is never asserted when fifo_notempty was 0 in the deciding IDLE cycle. At most one pop per request; minimum 3 cycles between pops (RD_LATENCY=1).
- Segment encoding: 0-9, A, b, C, d, E, F. HEX outputs are registered from the display register and hold between pops.

Optional Feature:
- Macro: HEX_LEADING_ZERO_BLANK_EN.
- Defined: HEX5..HEX1 are driven 7'b1111111 while their nibble and every higher nibble are 0. HEX0 is always lit.
  - Example: 24'h0000A5 shows only "A5".
  - Reset shows a single "0".
- Undefined: all six digits are always lit, including leading zeros.

Decomposition:
- Shared package lab3_pkg:
  - DATA_W, NIBBLES=6.
  - SEG_BLANK=7'h7F.
  - Segment constant array for 0..F.
  - typedef enum logic [1:0] rd_state_t {IDLE, POP, WAIT, CAPTURE}.
- Sub-module hex_to_seg7: purely combinational 4-bit to 7-bit decode, instantiated six times.
- Debounce and auto counter stay inline.

Test Plan:
- Reset with rst_n=0 for 3 cycles -> all HEX=7'b1000000, fifo_rd=0, busy=0, rd_underflow=0.
- FIFO holds 24'h12AB3F; key_rd_n low held 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one fifo_rd pulse 2+4+1 cycles after the low edge; two cycles later HEX5..HEX0 = 1,2,A,b,3,F.
- fifo_notempty=0, debounced key press -> rd_underflow one-cycle pulse, fifo_rd stays 0, display unchanged.
- Key bouncing low/high every 2 cycles for 20 cycles -> no fifo_rd. Key held low 100 cycles -> exactly one fifo_rd.
- auto_en=1, AUTO_PERIOD=16, three entries 24'h000001/24'h000002/24'h000003 then empty -> fifo_rd at cycles 16, 32, 48; final display 24'h000003; no underflow pulses.
- rst_n asserted during POP -> fifo_rd falls immediately, FSM returns to IDLE, display returns to zero; with HEX_LEADING_ZERO_BLANK_EN defined and data 24'h0000A5 -> HEX5..HEX2 = 7'h7F, HEX1="A", HEX0="5".
